mirror_witness_gen: RTL and testbench

MIRROR_WITNESS_GEN -- requirements
Module: mirror_witness_gen

---
 rtl/mirror_witness_gen.sv | 113 +++++++++++
 tb/tb_mirror_witness_gen.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mirror_witness_gen.sv
// rtl/mirror_witness_gen.sv - serial mirror-formula witness generator (optional self-check via MIRROR_SELF_CHECK_EN)
module mirror_witness_gen #(
    parameter int N = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_y,
    output logic         out_sat,
    output logic         busy
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_DONE = CW'(N);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [N-1:0]  x_sr;
    logic [N-1:0]  y_sr;
    logic [CW-1:0] cnt;
    logic [N-1:0]  y_shift;

    // LSB of x enters at the top of y; after N moves y holds x in original bit order.
    assign y_shift = (y_sr >> 1) | (N'(x_sr[0]) << (N - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)        state_nxt = SHIFT;
            SHIFT:   if (cnt == CNT_DONE) state_nxt = HOLD;
            HOLD:    if (out_ready)       state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_sr <= '0;
            y_sr <= '0;
            cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_sr <= in_x;
                        y_sr <= '0;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (cnt != CNT_DONE) begin
                        x_sr <= x_sr >> 1;
                        y_sr <= y_shift;
                        cnt  <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        x_sr <= '0;
                        y_sr <= '0;
                        cnt  <= '0;
                    end
                end
                default: begin
                    x_sr <= '0;
                    y_sr <= '0;
                    cnt  <= '0;
                end
            endcase
        end
    end

`ifdef MIRROR_SELF_CHECK_EN
    logic [N-1:0] x_copy;
    logic         sat_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_copy <= '0;
            sat_r  <= 1'b0;
        end else begin
            if (state == IDLE && in_valid)
                x_copy <= in_x;
            if (state == SHIFT && cnt == CNT_DONE)
                sat_r <= (y_sr == x_copy);
            else if (state == HOLD && out_ready)
                sat_r <= 1'b0;
        end
    end
`endif

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == HOLD);
        busy      = (state != IDLE);
        out_y     = (state == HOLD) ? y_sr : '0;
`ifdef MIRROR_SELF_CHECK_EN
        out_sat   = sat_r;
`else
        out_sat   = (state == HOLD);
`endif
    end
endmodule

// File: tb/tb_mirror_witness_gen.sv
// tb/tb_mirror_witness_gen.sv - directed and random bench for mirror_witness_gen (N=10 and N=1)
module tb_mirror_witness_gen;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, out_ready;
    logic [9:0] in_x;
    logic       in_ready, out_valid, out_sat, busy;
    logic [9:0] out_y;

    logic       b_in_valid, b_out_ready;
    logic [0:0] b_in_x;
    logic       b_in_ready, b_out_valid, b_out_sat, b_busy;
    logic [0:0] b_out_y;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int acc_count = 0;

    always #5 clk = ~clk;

    mirror_witness_gen #(.N(10)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_sat(out_sat), .busy(busy)
    );

    mirror_witness_gen #(.N(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_x(b_in_x),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_y(b_out_y), .out_sat(b_out_sat), .busy(b_busy)
    );

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready) hs_count++;
        if (rst_n && in_valid && in_ready) acc_count++;
    end

    task automatic run_job(input logic [9:0] x, input int stall, output int lat,
                           output logic [9:0] y, output logic sat, output logic hs_rdy, output logic ok);
        int t;
        ok = 1'b1; lat = 0; y = '0; sat = 1'b0; hs_rdy = 1'b0;
        @(negedge clk);
        in_valid = 1'b1; in_x = x; t = 0;
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        if (!in_ready) begin ok = 1'b0; in_valid = 1'b0; return; end
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        if (!out_valid) begin ok = 1'b0; return; end
        repeat (stall) @(negedge clk);
        y = out_y; sat = out_sat; hs_rdy = in_ready;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_x = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_x = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (out_y !== 10'h000) begin errors++; $display("FAIL reset_out_y got %h exp 000", out_y); end
        checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat got %b exp 0", out_sat); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_n1_in_ready got %b exp 1", b_in_ready); end
    endtask

    task automatic test_basic;
        int lat; logic [9:0] y; logic sat, hr, ok;
        run_job(10'h2B5, 0, lat, y, sat, hr, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_timeout got %b exp 1", ok); end
        checks++; if (lat != 11) begin errors++; $display("FAIL basic_latency got %0d exp 11", lat); end
        checks++; if (y !== 10'h2B5) begin errors++; $display("FAIL basic_y got %h exp 2b5", y); end
        checks++; if (sat !== 1'b1) begin errors++; $display("FAIL basic_sat got %b exp 1", sat); end
        checks++; if (hr !== 1'b0) begin errors++; $display("FAIL basic_hs_in_ready got %b exp 0", hr); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_after got %b exp 1", in_ready); end
        checks++; if (out_y !== 10'h000) begin errors++; $display("FAIL basic_y_cleared got %h exp 000", out_y); end
    endtask

    task automatic test_back_to_back;
        int lat; logic [9:0] y; logic sat, hr, ok;
        logic [9:0] xs [2];
        xs[0] = 10'h000; xs[1] = 10'h3FF;
        for (int i = 0; i < 2; i++) begin
            run_job(xs[i], 0, lat, y, sat, hr, ok);
            checks++; if (ok !== 1'b1 || y !== xs[i] || sat !== 1'b1 || lat != 11)
                begin errors++; $display("FAIL b2b_job%0d got y=%h sat=%b lat=%0d exp y=%h sat=1 lat=11", i, y, sat, lat, xs[i]); end
            checks++; if (hr !== 1'b0) begin errors++; $display("FAIL b2b_turnaround%0d got in_ready=%b exp 0", i, hr); end
        end
    endtask

    task automatic test_hold_stall;
        int t;
        @(negedge clk);
        in_valid = 1'b1; in_x = 10'h0AA;
        @(negedge clk);
        in_valid = 1'b0; t = 0;
        while (!out_valid && t < 100) begin @(negedge clk); t++; end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stall_reach_hold got %b exp 1", out_valid); end
        in_valid = 1'b1; in_x = 10'h155;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++; if (out_y !== 10'h0AA || in_ready !== 1'b0 || out_valid !== 1'b1)
                begin errors++; $display("FAIL stall_cycle%0d got y=%h rdy=%b vld=%b exp y=0aa rdy=0 vld=1", i, out_y, in_ready, out_valid); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        checks++; if (out_y !== 10'h0AA || out_sat !== 1'b1) begin errors++; $display("FAIL stall_release got y=%h sat=%b exp y=0aa sat=1", out_y, out_sat); end
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL stall_idle got rdy=%b vld=%b exp 1 0", in_ready, out_valid); end
    endtask

    task automatic test_reset_mid_shift;
        int lat, seen; logic [9:0] y; logic sat, hr, ok;
        @(negedge clk);
        in_valid = 1'b1; in_x = 10'h3C3;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid !== 1'b0) seen++;
            @(negedge clk);
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rst_mid_no_valid got %0d cycles exp 0", seen); end
        run_job(10'h0F0, 0, lat, y, sat, hr, ok);
        checks++; if (ok !== 1'b1 || lat != 11 || y !== 10'h0F0 || sat !== 1'b1)
            begin errors++; $display("FAIL rst_mid_next_job got y=%h sat=%b lat=%0d exp y=0f0 sat=1 lat=11", y, sat, lat); end
    endtask

    task automatic test_n1;
        int lat;
        @(negedge clk);
        b_in_valid = 1'b1; b_in_x = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0; lat = 0;
        while (!b_out_valid && lat < 20) begin @(negedge clk); lat++; end
        checks++; if (lat != 2) begin errors++; $display("FAIL n1_latency got %0d exp 2", lat); end
        checks++; if (b_out_y !== 1'b1 || b_out_sat !== 1'b1) begin errors++; $display("FAIL n1_output got y=%b sat=%b exp 1 1", b_out_y, b_out_sat); end
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        checks++; if (b_in_ready !== 1'b1 || b_out_y !== 1'b0) begin errors++; $display("FAIL n1_idle got rdy=%b y=%b exp 1 0", b_in_ready, b_out_y); end
    endtask

    task automatic test_random;
        int lat, bad, hs0, acc0; logic [9:0] x, y; logic sat, hr, ok;
        bad = 0; hs0 = hs_count; acc0 = acc_count;
        for (int j = 0; j < 1000; j++) begin
            x = 10'($urandom_range(0, 1023));
            run_job(x, $urandom_range(0, 3), lat, y, sat, hr, ok);
            if (ok !== 1'b1 || y !== x || sat !== 1'b1 || lat != 11) begin
                bad++;
                if (bad < 5) $display("FAIL random_job%0d got y=%h sat=%b lat=%0d exp y=%h sat=1 lat=11", j, y, sat, lat, x);
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL random_jobs got %0d bad exp 0", bad); end
        checks++; if (hs_count - hs0 != 1000) begin errors++; $display("FAIL random_handshakes got %0d exp 1000", hs_count - hs0); end
        checks++; if (acc_count - acc0 != 1000) begin errors++; $display("FAIL random_accepts got %0d exp 1000", acc_count - acc0); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_back_to_back;
        test_hold_stall;
        test_reset_mid_shift;
        test_n1;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
